multicycle_control: RTL and testbench

- Sequencing FSM for a multicycle build of the MIPS datapath: single shared memory, instruction register (IR), and shared ALU.
- Decodes the IR opcode and drives every datapath mux and write-enable, one micro-step per cycle.
- Stretches memory steps while memory reports not-ready.
- Counts retired instructions and traps on unsupported opcodes.

---
 rtl/multicycle_control.sv | 151 +++++++++++++++
 tb/tb_multicycle_control.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: sequencing FSM for a multicycle MIPS datapath with a shared memory and ALU.
// Every output is decoded from the current state, so reset clears all strobes without waiting for a clock.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Run,
    input  logic [5:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchNE,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic [1:0]       RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             Trap,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, REXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
        IEXEC = 4'd10, IWB = 4'd11, JAL = 4'd12, TRAP = 4'd15
    } state_t;
    state_t state, next;
    logic unused_zero;
    // The branch decision itself is made in the datapath from Zero and BranchNE.
    assign unused_zero = Zero;
    assign State = state;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state      <= FETCH;
            InstrCount <= '0;
        end else begin
            state <= next;
            if (next == FETCH && state != FETCH) InstrCount <= InstrCount + CNT_W'(1);
        end
    always_comb begin
        next        = state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 2'd0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        ALUOp       = 3'b000;
        PCSource    = 2'd0;
        Trap        = 1'b0;
        case (state)
            FETCH: begin
                MemRead = Run;
                ALUSrcB = 2'd1;
                IRWrite = Run & MemReady;
                PCWrite = Run & MemReady;
                next    = (Run & MemReady) ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'd3;
                next = (Opcode == 6'h00) ? REXEC :
                       (Opcode == 6'h23 || Opcode == 6'h2B) ? MEMADR :
                       (Opcode == 6'h04 || Opcode == 6'h05) ? BRANCH :
                       (Opcode == 6'h08 || Opcode == 6'h0C ||
                        Opcode == 6'h0D || Opcode == 6'h0F) ? IEXEC :
                       (Opcode == 6'h02) ? JUMP :
                       (Opcode == 6'h03) ? JAL : TRAP;
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                next    = (Opcode == 6'h23) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                next    = MemReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                next     = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                next     = MemReady ? FETCH : MEMWR;
            end
            REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b111;
                next    = RWB;
            end
            RWB: begin
                RegDst   = 2'd1;
                RegWrite = 1'b1;
                next     = FETCH;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'd1;
                BranchNE    = (Opcode == 6'h05);
                next        = FETCH;
            end
            IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                ALUOp   = (Opcode == 6'h0C) ? 3'b011 :
                          (Opcode == 6'h0D) ? 3'b010 :
                          (Opcode == 6'h0F) ? 3'b100 : 3'b000;
                next    = IWB;
            end
            IWB: begin
                RegWrite = 1'b1;
                next     = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'd2;
                next     = FETCH;
            end
            JAL: begin
                RegDst   = 2'd2;
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                PCSource = 2'd2;
                next     = FETCH;
            end
            default: begin
                Trap = 1'b1;
                next = TRAP;
            end
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven check of every state's control word plus reset and trap sequences.
module tb_multicycle_control;
    logic clk = 1'b0, reset = 1'b0, Run = 1'b0, Zero = 1'b0, MemReady = 1'b1;
    logic [5:0] Opcode = 6'h00;
    logic PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, Trap;
    logic [1:0] RegDst, ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] State;
    logic [31:0] InstrCount;
    int checks = 0, errors = 0;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Run(Run), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .Trap(Trap), .State(State), .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    logic [19:0] act;
    assign act = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Trap};

    function automatic logic [19:0] ctl(input int pcw, pcc, bne, iord, mrd, mwr, irw, m2r,
                                        input int rdst, rw, asa, asb, aop, pcs, trap);
        return {1'(pcw), 1'(pcc), 1'(bne), 1'(iord), 1'(mrd), 1'(mwr), 1'(irw), 1'(m2r),
                2'(rdst), 1'(rw), 1'(asa), 2'(asb), 3'(aop), 2'(pcs), 1'(trap)};
    endfunction

    typedef struct {
        logic        run;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [19:0] c;
        int          cnt;
    } vec_t;
    vec_t v[$];

    task automatic add(input logic r, input logic [5:0] o, input logic m, input logic [3:0] s,
                       input logic [19:0] c, input int n);
        v.push_back('{r, o, m, s, c, n});
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s (row %0d): got %h expected %h", name, row, a, e);
        end
    endtask

    task automatic check_all(input string tag, input int row, input logic [3:0] st,
                             input logic [19:0] c, input int n);
        chk({tag, " state"}, row, 32'(State), 32'(st));
        chk({tag, " ctl"}, row, 32'(act), 32'(c));
        chk({tag, " count"}, row, InstrCount, 32'(n));
    endtask

    logic [19:0] F11, F10, F00, DEC, REX, RWB, MAD, MRD, MWB, MWR, BNE, BEQ, IWB, JMP, JAL, TRP;

    initial begin
        F11 = ctl(1,0,0,0,1,0,1,0,0,0,0,1,0,0,0);
        F10 = ctl(0,0,0,0,1,0,0,0,0,0,0,1,0,0,0);
        F00 = ctl(0,0,0,0,0,0,0,0,0,0,0,1,0,0,0);
        DEC = ctl(0,0,0,0,0,0,0,0,0,0,0,3,0,0,0);
        REX = ctl(0,0,0,0,0,0,0,0,0,0,1,0,7,0,0);
        RWB = ctl(0,0,0,0,0,0,0,0,1,1,0,0,0,0,0);
        MAD = ctl(0,0,0,0,0,0,0,0,0,0,1,2,0,0,0);
        MRD = ctl(0,0,0,1,1,0,0,0,0,0,0,0,0,0,0);
        MWB = ctl(0,0,0,0,0,0,0,1,0,1,0,0,0,0,0);
        MWR = ctl(0,0,0,1,0,1,0,0,0,0,0,0,0,0,0);
        BNE = ctl(0,1,1,0,0,0,0,0,0,0,1,0,1,1,0);
        BEQ = ctl(0,1,0,0,0,0,0,0,0,0,1,0,1,1,0);
        IWB = ctl(0,0,0,0,0,0,0,0,0,1,0,0,0,0,0);
        JMP = ctl(1,0,0,0,0,0,0,0,0,0,0,0,0,2,0);
        JAL = ctl(1,0,0,0,0,0,0,0,2,1,0,0,0,2,0);
        TRP = ctl(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1);

        add(1, 6'h00, 1, 0, F11, 0); add(1, 6'h00, 1, 1, DEC, 0);
        add(1, 6'h00, 1, 6, REX, 0); add(1, 6'h00, 1, 7, RWB, 0);
        add(1, 6'h23, 1, 0, F11, 1); add(1, 6'h23, 1, 1, DEC, 1); add(1, 6'h23, 1, 2, MAD, 1);
        add(1, 6'h23, 0, 3, MRD, 1); add(1, 6'h23, 0, 3, MRD, 1); add(1, 6'h23, 0, 3, MRD, 1);
        add(1, 6'h23, 1, 3, MRD, 1); add(1, 6'h23, 1, 4, MWB, 1);
        add(1, 6'h2B, 1, 0, F11, 2); add(1, 6'h2B, 1, 1, DEC, 2); add(1, 6'h2B, 1, 2, MAD, 2);
        add(1, 6'h2B, 0, 5, MWR, 2); add(1, 6'h2B, 1, 5, MWR, 2);
        add(1, 6'h05, 1, 0, F11, 3); add(1, 6'h05, 1, 1, DEC, 3); add(1, 6'h05, 1, 8, BNE, 3);
        add(1, 6'h04, 1, 0, F11, 4); add(1, 6'h04, 1, 1, DEC, 4); add(1, 6'h04, 1, 8, BEQ, 4);
        add(1, 6'h08, 1, 0, F11, 5); add(1, 6'h08, 1, 1, DEC, 5);
        add(1, 6'h08, 1, 10, ctl(0,0,0,0,0,0,0,0,0,0,1,2,0,0,0), 5); add(1, 6'h08, 1, 11, IWB, 5);
        add(1, 6'h0C, 1, 0, F11, 6); add(1, 6'h0C, 1, 1, DEC, 6);
        add(1, 6'h0C, 1, 10, ctl(0,0,0,0,0,0,0,0,0,0,1,2,3,0,0), 6); add(1, 6'h0C, 1, 11, IWB, 6);
        add(1, 6'h0D, 1, 0, F11, 7); add(1, 6'h0D, 1, 1, DEC, 7);
        add(1, 6'h0D, 1, 10, ctl(0,0,0,0,0,0,0,0,0,0,1,2,2,0,0), 7); add(1, 6'h0D, 1, 11, IWB, 7);
        add(1, 6'h0F, 1, 0, F11, 8); add(1, 6'h0F, 1, 1, DEC, 8);
        add(1, 6'h0F, 1, 10, ctl(0,0,0,0,0,0,0,0,0,0,1,2,4,0,0), 8); add(1, 6'h0F, 1, 11, IWB, 8);
        add(1, 6'h02, 1, 0, F11, 9); add(1, 6'h02, 1, 1, DEC, 9); add(1, 6'h02, 1, 9, JMP, 9);
        add(1, 6'h03, 1, 0, F11, 10); add(1, 6'h03, 1, 1, DEC, 10); add(1, 6'h03, 1, 12, JAL, 10);
        for (int i = 0; i < 5; i++) add(0, 6'h00, 1, 0, F00, 11);
        add(1, 6'h00, 0, 0, F10, 11); add(1, 6'h00, 0, 0, F10, 11);
        add(1, 6'h00, 1, 0, F11, 11); add(0, 6'h00, 1, 1, DEC, 11);
        add(0, 6'h00, 1, 6, REX, 11); add(0, 6'h00, 1, 7, RWB, 11); add(0, 6'h00, 1, 0, F00, 12);

        #1;
        check_all("reset", -1, 0, F00, 0);
        @(negedge clk);
        reset = 1'b1;
        foreach (v[i]) begin
            @(negedge clk);
            Run = v[i].run; Opcode = v[i].op; MemReady = v[i].mr;
            #1;
            check_all("vec", i, v[i].st, v[i].c, v[i].cnt);
        end

        // reset in the middle of a stalled store: strobe must drop before the next edge
        @(negedge clk); Run = 1; Opcode = 6'h2B; MemReady = 1;
        @(negedge clk); @(negedge clk);
        @(negedge clk); MemReady = 0;
        #1;
        check_all("memwr", 0, 5, MWR, 12);
        #2 reset = 1'b0; Run = 0;
        #1;
        chk("async MemWrite", 0, 32'(MemWrite), 0);
        chk("async state", 0, 32'(State), 0);
        chk("async count", 0, InstrCount, 0);
        @(negedge clk); reset = 1'b1; MemReady = 1;

        // one jump retires, then an illegal opcode parks the FSM in TRAP
        @(negedge clk); Run = 1; Opcode = 6'h02;
        @(negedge clk); @(negedge clk);
        @(negedge clk); Opcode = 6'h3F;
        #1;
        check_all("trap fetch", 0, 0, F11, 1);
        @(negedge clk);
        #1;
        check_all("trap decode", 0, 1, DEC, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check_all("trap hold", i, 15, TRP, 1);
        end
        Run = 0;
        reset = 1'b0;
        #1;
        check_all("trap reset", 0, 0, F00, 0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        #1;
        check_all("post reset", 0, 0, F00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
